pc_ras_unit: RTL and testbench

PC_RAS_UNIT -- requirements
Module: pc_ras_unit

---
 rtl/pc_ras_unit_if.sv | 29 ++
 rtl/pc_ras_unit.sv | 103 ++++++++++
 tb/tb_pc_ras_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pc_ras_unit_if.sv
// Bundle of control inputs and PC/RAS status outputs for pc_ras_unit.
// The master side drives control; the slave side (the PC unit) drives status.
interface pc_ras_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            PC_stall;
    logic            PC_jump_enb;
    logic [XLEN-1:0] PC_jump_add;
    logic            PC_call;
    logic            PC_ret;
    logic            PC_trap;
    logic            PC_mret;
    logic [XLEN-1:0] PC_counter;
    logic [XLEN-1:0] PC_next;
    logic [XLEN-1:0] PC_epc;
    logic            PC_misaligned;
    logic            PC_ras_empty;
    logic            PC_ras_full;

    modport master (
        output PC_stall, PC_jump_enb, PC_jump_add, PC_call, PC_ret, PC_trap, PC_mret,
        input  PC_counter, PC_next, PC_epc, PC_misaligned, PC_ras_empty, PC_ras_full
    );

    modport slave (
        input  PC_stall, PC_jump_enb, PC_jump_add, PC_call, PC_ret, PC_trap, PC_mret,
        output PC_counter, PC_next, PC_epc, PC_misaligned, PC_ras_empty, PC_ras_full
    );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter with trap/mret redirect and a circular return-address stack.
// Next-PC priority: reset > trap > mret > ret > jump > stall > sequential.
module pc_ras_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic          PC_clk,
    input  logic          PC_rst,
    pc_ras_unit_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;
    logic [PtrW-1:0] sp_q, sp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic            push;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;

    assign pc_plus4  = pc_q + XLEN'(4);
    assign ras_top   = ras_q[sp_q - PtrW'(1)];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));

    always_comb begin
        pc_d  = pc_plus4;
        epc_d = epc_q;
        mis_d = 1'b0;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (PC_rst) begin
            pc_d  = RESET_VEC;
            epc_d = '0;
            sp_d  = '0;
            cnt_d = '0;
        end else if (bus.PC_trap) begin
            pc_d  = TRAP_VEC;
            epc_d = pc_q;
        end else if (bus.PC_mret) begin
            pc_d = epc_q;
        end else if (bus.PC_ret) begin
            if (ras_empty) begin
                pc_d = bus.PC_jump_add;
            end else begin
                pc_d  = ras_top;
                sp_d  = sp_q - PtrW'(1);
                cnt_d = cnt_q - CntW'(1);
            end
        end else if (bus.PC_jump_enb) begin
            if (bus.PC_jump_add[1:0] == 2'b00) begin
                pc_d = bus.PC_jump_add;
                if (bus.PC_call) begin
                    // When full, slot sp_q holds the oldest entry, so it is overwritten.
                    push = 1'b1;
                    sp_d = sp_q + PtrW'(1);
                    if (!ras_full) cnt_d = cnt_q + CntW'(1);
                end
            end else begin
                pc_d  = pc_q;
                mis_d = 1'b1;
            end
        end else if (bus.PC_stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge PC_clk) begin
        if (PC_rst) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            mis_q <= 1'b0;
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack contents are not reset; occupancy alone defines validity.
    always_ff @(posedge PC_clk) begin
        if (push) ras_q[sp_q] <= pc_plus4;
    end

    assign bus.PC_counter    = pc_q;
    assign bus.PC_next       = pc_d;
    assign bus.PC_epc        = epc_q;
    assign bus.PC_misaligned = mis_q;
    assign bus.PC_ras_empty  = ras_empty;
    assign bus.PC_ras_full   = ras_full;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit with hand-computed expected PC, EPC and stack flags.
module tb_pc_ras_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_ras_unit_if #(.XLEN(32)) bus ();

    pc_ras_unit #(
        .XLEN(32),
        .RESET_VEC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .RAS_DEPTH(4)
    ) dut (
        .PC_clk(clk),
        .PC_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic je, input logic [31:0] ja, input logic ca,
                         input logic re, input logic tr, input logic mr);
        bus.PC_stall    = st;
        bus.PC_jump_enb = je;
        bus.PC_jump_add = ja;
        bus.PC_call     = ca;
        bus.PC_ret      = re;
        bus.PC_trap     = tr;
        bus.PC_mret     = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic jmp(input logic [31:0] a, input logic ca);
        drive(0, 1, a, ca, 0, 0, 0);
        tick();
    endtask

    task automatic ret(input logic [31:0] a);
        drive(0, 0, a, 0, 1, 0, 0);
        tick();
    endtask

    initial begin
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        // Reset, with a trap asserted to show it is ignored
        rst = 1'b1;
        drive(0, 1, 32'h300, 1, 0, 1, 0);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        #1;
        chk("rst_pc", bus.PC_counter, 32'h0);
        chk("rst_epc", bus.PC_epc, 32'h0);
        chk("rst_mis", bus.PC_misaligned, 0);
        chk("rst_empty", bus.PC_ras_empty, 1);
        chk("rst_full", bus.PC_ras_full, 0);
        chk("rst_next", bus.PC_next, 32'h4);

        // Sequential then stall
        idle(); chk("seq_4", bus.PC_counter, 32'h4);
        idle(); chk("seq_8", bus.PC_counter, 32'h8);
        idle(); chk("seq_c", bus.PC_counter, 32'hC);
        drive(1, 0, 32'h0, 0, 0, 0, 0);
        #1 chk("stall_next", bus.PC_next, 32'hC);
        tick(); chk("stall_hold", bus.PC_counter, 32'hC);

        // Call and return
        idle(); chk("seq_10", bus.PC_counter, 32'h10);
        jmp(32'h200, 1);
        chk("call_pc", bus.PC_counter, 32'h200);
        chk("call_nonempty", bus.PC_ras_empty, 0);
        ret(32'h0);
        chk("ret_pc", bus.PC_counter, 32'h14);
        chk("ret_empty", bus.PC_ras_empty, 1);

        // Nested calls overflow a depth-4 stack
        jmp(32'h0, 0);   chk("jmp_0", bus.PC_counter, 32'h0);
        jmp(32'h100, 1);
        jmp(32'h200, 1);
        jmp(32'h300, 1);
        chk("full_3", bus.PC_ras_full, 0);
        jmp(32'h400, 1);
        chk("full_4", bus.PC_ras_full, 1);
        jmp(32'h500, 1);
        chk("full_5", bus.PC_ras_full, 1);
        ret(32'h0); chk("ret1", bus.PC_counter, 32'h404);
        ret(32'h0); chk("ret2", bus.PC_counter, 32'h304);
        ret(32'h0); chk("ret3", bus.PC_counter, 32'h204);
        ret(32'h0); chk("ret4", bus.PC_counter, 32'h104);
        chk("ret4_empty", bus.PC_ras_empty, 1);
        ret(32'h80); chk("ret_empty_fallback", bus.PC_counter, 32'h80);
        chk("ret5_empty", bus.PC_ras_empty, 1);

        // Trap overrides stall, then mret
        jmp(32'h40, 0);
        drive(1, 0, 32'h0, 0, 0, 1, 0);
        tick();
        chk("trap_pc", bus.PC_counter, 32'h100);
        chk("trap_epc", bus.PC_epc, 32'h40);
        drive(0, 0, 32'h0, 0, 0, 0, 1);
        tick();
        chk("mret_pc", bus.PC_counter, 32'h40);
        chk("mret_epc", bus.PC_epc, 32'h40);

        // Misaligned jump: hold, one-cycle flag, no push
        jmp(32'h60, 1);
        chk("call2_pc", bus.PC_counter, 32'h60);
        jmp(32'h202, 1);
        chk("mis_hold", bus.PC_counter, 32'h60);
        chk("mis_flag", bus.PC_misaligned, 1);
        idle();
        chk("mis_clear", bus.PC_misaligned, 0);
        chk("mis_seq", bus.PC_counter, 32'h64);
        ret(32'h0);
        chk("mis_ret", bus.PC_counter, 32'h44);
        chk("mis_ret_empty", bus.PC_ras_empty, 1);

        // Ret beats jump+call in the same cycle; no push
        jmp(32'h300, 1);
        drive(0, 1, 32'h500, 1, 1, 0, 0);
        tick();
        chk("retjmp_pc", bus.PC_counter, 32'h48);
        chk("retjmp_empty", bus.PC_ras_empty, 1);
        ret(32'h600); chk("retjmp_fallback", bus.PC_counter, 32'h600);

        // Wrap-around and trap priority over mret/jump
        jmp(32'hFFFF_FFFC, 0);
        chk("wrap_pre", bus.PC_counter, 32'hFFFF_FFFC);
        idle(); chk("wrap", bus.PC_counter, 32'h0);
        drive(0, 1, 32'h800, 0, 0, 1, 1);
        #1 chk("prio_next", bus.PC_next, 32'h100);
        tick();
        chk("prio_pc", bus.PC_counter, 32'h100);
        chk("prio_epc", bus.PC_epc, 32'h0);

        // Reset mid-call discards stack and epc
        jmp(32'h200, 1);
        chk("pre_rst_empty", bus.PC_ras_empty, 0);
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 1, 0);
        #1 chk("rst_next2", bus.PC_next, 32'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        #1;
        chk("rst2_pc", bus.PC_counter, 32'h0);
        chk("rst2_epc", bus.PC_epc, 32'h0);
        chk("rst2_empty", bus.PC_ras_empty, 1);
        ret(32'h90); chk("rst2_ret", bus.PC_counter, 32'h90);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
